alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 16-bit saturating ALU between two requesters: req0 = pipeline EX stage,
//  req1 = branch/address-calc unit. Round-robin (or fixed-priority) grant; drives ALU operands
//  from the winner; registers result into a one-entry response buffer with valid/ready.
//  Keeps a per-requester {zr,ov,ne} flag register with the ALU flag-update rules.
// PARAMETERS
//  FIXED_PRI  0  1 = req0 always wins; 0 = round-robin
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   reset, asynchronous, active-low
//  reqN_vld     in   1   N=0,1: request valid; ctrl/src0/src1/shamt held stable while vld & !gnt
//  reqN_ctrl    in   3   ALU opcode (000 add, 001 lhb, 010 sub, 011 and, 100 nor, 101 sll, 110 srl, 111 sra)
//  reqN_src0    in   16  operand 0
//  reqN_src1    in   16  operand 1
//  reqN_shamt   in   4   shift amount
//  reqN_gnt     out  1   accept strobe; transfer occurs when reqN_vld & reqN_gnt
//  alu_ctrl     out  3   to ALU ctrl
//  alu_src0     out  16  to ALU src0
//  alu_src1     out  16  to ALU src1
//  alu_shamt    out  4   to ALU shamt
//  alu_result   in   16  from ALU (combinational, same cycle)
//  alu_ov       in   1   from ALU
//  alu_zr       in   1   from ALU
//  alu_ne       in   1   from ALU
//  rsp_vld      out  1   response buffer holds a result
//  rsp_id       out  1   requester that issued the buffered result
//  rsp_result   out  16  buffered ALU result
//  rsp_ready    in   1   consumer takes the response when rsp_vld & rsp_ready
//  flags0       out  3   {zr,ov,ne} for req0
//  flags1       out  3   {zr,ov,ne} for req1
// BEHAVIOUR
//  - Reset (rst_n=0, async): rsp_vld=0, rsp_id=0, rsp_result=0, flags0=flags1=0, last=1 (req0 wins
//    first tie). Resetting mid-op drops any buffered response; no grant issues while rst_n=0.
//  - Buffer states: EMPTY (rsp_vld=0), FULL (rsp_vld=1). can_acc = EMPTY | (FULL & rsp_ready).
//  - Grant (combinational): gnt asserts only if can_acc and the requester is vld. One vld -> it wins.
//    Both vld: FIXED_PRI=1 -> req0; else winner = ~last. Never both gnt in one cycle.
//  - ALU drive: winner's ctrl/src0/src1/shamt; no grant -> all zeros (ctrl=000).
//  - On accept (edge): rsp_result<=alu_result, rsp_id<=winner, rsp_vld<=1, last<=winner (RR only).
//  - Latency: 1 cycle accept->rsp_vld. FULL & rsp_ready & new accept -> buffer reloads same edge,
//    rsp_vld stays 1 (back-to-back throughput 1/cycle). FULL & rsp_ready & no accept -> EMPTY.
//  - FULL & !rsp_ready -> no grants, buffer and flags hold.
//  - Flags for winner on accept: zr<=alu_zr always; ov<=alu_ov, ne<=alu_ne only when ctrl is
//    000 or 010; other opcodes hold ov/ne. Non-winner flags untouched.
//  - Requester deasserting vld without gnt is legal (request withdrawn, no state change).
//  - Width: all datapath 16 bit; no arithmetic in this block, saturation is the ALU's.
// TESTING
//  1. Reset then req0 add 0x7FFF+0x0001, rsp_ready=1 -> gnt0 same cycle; next cycle rsp_vld=1,
//     rsp_id=0, rsp_result=0x7FFF, flags0={0,1,0}.
//  2. Both vld every cycle, rsp_ready=1, FIXED_PRI=0 -> grants alternate 0,1,0,1; rsp_vld constant 1.
//  3. req1 sub 0x0005-0x0005 then req1 and 0x00F0&0x000F after flags1={0,1,1} preset by sub
//     0x8000-0x0001 -> after sub 5-5 flags1={1,0,0}; after and flags1={1,0,0} (ov/ne held, zr=1).
//  4. rsp_ready=0 with buffer FULL and req0 vld 3 cycles -> gnt0=0, rsp_result stable;
//     raise rsp_ready -> gnt0=1 same cycle, new result next edge.
//  5. rst_n pulled low asynchronously (mid-cycle) while FULL -> rsp_vld=0 immediately, flags 0,
//     next tie after release grants req0.
//  6. FIXED_PRI=1, both vld 4 cycles -> gnt0 all 4, gnt1 never; req1 served first cycle req0 idle.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared 16-bit saturating ALU: grants one requester per cycle,
// drives the ALU from the winner, buffers the result and keeps per-requester {zr,ov,ne} flags.
module alu_arbiter #(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_vld,
    input  logic [2:0]  req0_ctrl,
    input  logic [15:0] req0_src0,
    input  logic [15:0] req0_src1,
    input  logic [3:0]  req0_shamt,
    output logic        req0_gnt,
    input  logic        req1_vld,
    input  logic [2:0]  req1_ctrl,
    input  logic [15:0] req1_src0,
    input  logic [15:0] req1_src1,
    input  logic [3:0]  req1_shamt,
    output logic        req1_gnt,
    output logic [2:0]  alu_ctrl,
    output logic [15:0] alu_src0,
    output logic [15:0] alu_src1,
    output logic [3:0]  alu_shamt,
    input  logic [15:0] alu_result,
    input  logic        alu_ov,
    input  logic        alu_zr,
    input  logic        alu_ne,
    output logic        rsp_vld,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    input  logic        rsp_ready,
    output logic [2:0]  flags0,
    output logic [2:0]  flags1
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 3;
    localparam int unsigned SW = 4;
    localparam int unsigned FW = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    buf_state_e    state_q, state_d;
    logic          rsp_id_q, rsp_id_d;
    logic [DW-1:0] rsp_result_q, rsp_result_d;
    logic          last_q, last_d;
    logic [FW-1:0] flags0_q, flags0_d;
    logic [FW-1:0] flags1_q, flags1_d;

    logic          can_acc;
    logic          win1;
    logic          accept;
    logic          arith_op;
    logic [FW-1:0] win_flags;
    logic [FW-1:0] new_flags;

    // Grant: only one requester may win; ties go to ~last (round-robin) or to req0 (fixed).
    always_comb begin
        can_acc = (state_q == EMPTY) | rsp_ready;
        win1    = 1'b0;
        if (req0_vld && req1_vld) begin
            win1 = (FIXED_PRI == 1'b0) ? ~last_q : 1'b0;
        end else begin
            win1 = req1_vld;
        end
        req0_gnt = rst_n & can_acc & req0_vld & ~win1;
        req1_gnt = rst_n & can_acc & req1_vld & win1;
        accept   = req0_gnt | req1_gnt;
    end

    // ALU operand mux: zeros whenever nobody is granted.
    always_comb begin
        alu_ctrl  = CW'(0);
        alu_src0  = DW'(0);
        alu_src1  = DW'(0);
        alu_shamt = SW'(0);
        if (req0_gnt) begin
            alu_ctrl  = req0_ctrl;
            alu_src0  = req0_src0;
            alu_src1  = req0_src1;
            alu_shamt = req0_shamt;
        end else if (req1_gnt) begin
            alu_ctrl  = req1_ctrl;
            alu_src0  = req1_src0;
            alu_src1  = req1_src1;
            alu_shamt = req1_shamt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= DW'(0);
            last_q       <= 1'b1;
            flags0_q     <= FW'(0);
            flags1_q     <= FW'(0);
        end else begin
            state_q      <= state_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            last_q       <= last_d;
            flags0_q     <= flags0_d;
            flags1_q     <= flags1_d;
        end
    end

    // Buffer next state; ov/ne only follow the ALU for add and sub, zr follows every op.
    always_comb begin
        state_d      = state_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        last_d       = last_q;
        flags0_d     = flags0_q;
        flags1_d     = flags1_q;
        arith_op     = (alu_ctrl == 3'b000) || (alu_ctrl == 3'b010);
        win_flags    = win1 ? flags1_q : flags0_q;
        new_flags    = {alu_zr,
                        arith_op ? alu_ov : win_flags[1],
                        arith_op ? alu_ne : win_flags[0]};

        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (rsp_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        if (accept) begin
            rsp_result_d = alu_result;
            rsp_id_d     = win1;
            if (FIXED_PRI == 1'b0) begin
                last_d = win1;
            end
            if (win1) begin
                flags1_d = new_flags;
            end else begin
                flags0_d = new_flags;
            end
        end
    end

    assign rsp_vld    = (state_q == FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign flags0     = flags0_q;
    assign flags1     = flags1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each driven by a behavioural saturating ALU.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_vld = 1'b0, req1_vld = 1'b0, rsp_ready = 1'b1;
    logic [2:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic [15:0] req0_src0 = '0, req0_src1 = '0, req1_src0 = '0, req1_src1 = '0;
    logic [3:0]  req0_shamt = '0, req1_shamt = '0;

    logic        rr_gnt0, rr_gnt1, rr_vld, rr_id, rr_ov, rr_zr, rr_ne;
    logic [2:0]  rr_ctrl, rr_f0, rr_f1;
    logic [15:0] rr_s0, rr_s1, rr_res, rr_rsp;
    logic [3:0]  rr_sh;
    logic        fp_gnt0, fp_gnt1, fp_vld, fp_id, fp_ov, fp_zr, fp_ne;
    logic [2:0]  fp_ctrl, fp_f0, fp_f1;
    logic [15:0] fp_s0, fp_s1, fp_res, fp_rsp;
    logic [3:0]  fp_sh;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    // Saturating ALU reference: returns {ov, zr, ne, result}.
    function automatic logic [18:0] alu_f(input logic [2:0] c, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] sh);
        logic [15:0] r;
        logic        ov;
        ov = 1'b0;
        case (c)
            3'b000: begin
                r = a + b;
                if (a[15] == b[15] && r[15] != a[15]) begin
                    ov = 1'b1;
                    r  = a[15] ? 16'h8000 : 16'h7FFF;
                end
            end
            3'b010: begin
                r = a - b;
                if (a[15] != b[15] && r[15] != a[15]) begin
                    ov = 1'b1;
                    r  = a[15] ? 16'h8000 : 16'h7FFF;
                end
            end
            3'b001:  r = {b[7:0], a[7:0]};
            3'b011:  r = a & b;
            3'b100:  r = ~(a | b);
            3'b101:  r = a << sh;
            3'b110:  r = a >> sh;
            default: r = 16'($signed(a) >>> sh);
        endcase
        return {ov, (r == 16'h0000), r[15], r};
    endfunction

    assign {rr_ov, rr_zr, rr_ne, rr_res} = alu_f(rr_ctrl, rr_s0, rr_s1, rr_sh);
    assign {fp_ov, fp_zr, fp_ne, fp_res} = alu_f(fp_ctrl, fp_s0, fp_s1, fp_sh);

    alu_arbiter #(.FIXED_PRI(1'b0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_vld(req0_vld), .req0_ctrl(req0_ctrl), .req0_src0(req0_src0),
        .req0_src1(req0_src1), .req0_shamt(req0_shamt), .req0_gnt(rr_gnt0),
        .req1_vld(req1_vld), .req1_ctrl(req1_ctrl), .req1_src0(req1_src0),
        .req1_src1(req1_src1), .req1_shamt(req1_shamt), .req1_gnt(rr_gnt1),
        .alu_ctrl(rr_ctrl), .alu_src0(rr_s0), .alu_src1(rr_s1), .alu_shamt(rr_sh),
        .alu_result(rr_res), .alu_ov(rr_ov), .alu_zr(rr_zr), .alu_ne(rr_ne),
        .rsp_vld(rr_vld), .rsp_id(rr_id), .rsp_result(rr_rsp), .rsp_ready(rsp_ready),
        .flags0(rr_f0), .flags1(rr_f1)
    );

    alu_arbiter #(.FIXED_PRI(1'b1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_vld(req0_vld), .req0_ctrl(req0_ctrl), .req0_src0(req0_src0),
        .req0_src1(req0_src1), .req0_shamt(req0_shamt), .req0_gnt(fp_gnt0),
        .req1_vld(req1_vld), .req1_ctrl(req1_ctrl), .req1_src0(req1_src0),
        .req1_src1(req1_src1), .req1_shamt(req1_shamt), .req1_gnt(fp_gnt1),
        .alu_ctrl(fp_ctrl), .alu_src0(fp_s0), .alu_src1(fp_s1), .alu_shamt(fp_sh),
        .alu_result(fp_res), .alu_ov(fp_ov), .alu_zr(fp_zr), .alu_ne(fp_ne),
        .rsp_vld(fp_vld), .rsp_id(fp_id), .rsp_result(fp_rsp), .rsp_ready(rsp_ready),
        .flags0(fp_f0), .flags1(fp_f1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req0(input logic v, input logic [2:0] c, input logic [15:0] a,
                            input logic [15:0] b);
        req0_vld = v; req0_ctrl = c; req0_src0 = a; req0_src1 = b; req0_shamt = 4'd0;
    endtask

    task automatic set_req1(input logic v, input logic [2:0] c, input logic [15:0] a,
                            input logic [15:0] b);
        req1_vld = v; req1_ctrl = c; req1_src0 = a; req1_src1 = b; req1_shamt = 4'd0;
    endtask

    initial begin
        do_reset();
        #1;
        check("rst_rsp_vld", 32'(rr_vld), 32'd0);
        check("rst_rsp_id", 32'(rr_id), 32'd0);
        check("rst_rsp_result", 32'(rr_rsp), 32'd0);
        check("rst_flags", 32'({rr_f0, rr_f1}), 32'd0);
        check("rst_alu_ctrl", 32'(rr_ctrl), 32'd0);

        // Saturating add through req0.
        set_req0(1'b1, 3'b000, 16'h7FFF, 16'h0001);
        #1;
        check("t1_gnt0", 32'(rr_gnt0), 32'd1);
        check("t1_alu_src0", 32'(rr_s0), 32'h7FFF);
        tick();
        set_req0(1'b0, 3'b000, 16'h0000, 16'h0000);
        check("t1_rsp_vld", 32'(rr_vld), 32'd1);
        check("t1_rsp_id", 32'(rr_id), 32'd0);
        check("t1_rsp_result", 32'(rr_rsp), 32'h7FFF);
        check("t1_flags0", 32'(rr_f0), 32'b010);
        check("t1_flags1", 32'(rr_f1), 32'b000);

        // Round-robin alternation with both requesters always valid.
        do_reset();
        set_req0(1'b1, 3'b000, 16'h0001, 16'h0002);
        set_req1(1'b1, 3'b000, 16'h0010, 16'h0020);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_gnt0", 32'(rr_gnt0), 32'(i % 2 == 0));
            check("t2_gnt1", 32'(rr_gnt1), 32'(i % 2 == 1));
            tick();
            check("t2_rsp_vld", 32'(rr_vld), 32'd1);
            check("t2_rsp_id", 32'(rr_id), 32'(i % 2));
            check("t2_rsp_result", 32'(rr_rsp), (i % 2 == 0) ? 32'h0003 : 32'h0030);
        end

        // req1 flag rules: ov/ne only move on add/sub, zr on every op.
        set_req0(1'b0, 3'b000, 16'h0000, 16'h0000);
        set_req1(1'b1, 3'b010, 16'h8000, 16'h0001);
        #1;
        check("t3_gnt1", 32'(rr_gnt1), 32'd1);
        tick();
        check("t3_sub_sat_res", 32'(rr_rsp), 32'h8000);
        check("t3_flags1_preset", 32'(rr_f1), 32'b011);
        set_req1(1'b1, 3'b011, 16'h00F0, 16'h0030);
        tick();
        check("t3_flags1_and_hold", 32'(rr_f1), 32'b011);
        set_req1(1'b1, 3'b010, 16'h0005, 16'h0005);
        tick();
        check("t3_flags1_sub_zero", 32'(rr_f1), 32'b100);
        set_req1(1'b1, 3'b011, 16'h00F0, 16'h000F);
        tick();
        set_req1(1'b0, 3'b000, 16'h0000, 16'h0000);
        check("t3_flags1_and_zero", 32'(rr_f1), 32'b100);
        check("t3_rsp_result", 32'(rr_rsp), 32'h0000);
        check("t3_flags0_untouched", 32'(rr_f0), 32'b000);

        // Backpressure: FULL and not ready stalls all grants.
        rsp_ready = 1'b0;
        set_req0(1'b1, 3'b000, 16'h1234, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_gnt0_stall", 32'(rr_gnt0), 32'd0);
            check("t4_alu_ctrl_idle", 32'(rr_s0), 32'd0);
            tick();
            check("t4_rsp_hold", 32'(rr_rsp), 32'h0000);
            check("t4_rsp_vld_hold", 32'(rr_vld), 32'd1);
        end
        rsp_ready = 1'b1;
        #1;
        check("t4_gnt0_release", 32'(rr_gnt0), 32'd1);
        tick();
        check("t4_new_result", 32'(rr_rsp), 32'h1235);
        check("t4_new_id", 32'(rr_id), 32'd0);

        // Asynchronous reset mid-cycle while FULL.
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rsp_vld_async", 32'(rr_vld), 32'd0);
        check("t5_flags_async", 32'({rr_f0, rr_f1}), 32'd0);
        check("t5_no_gnt_in_rst", 32'({rr_gnt0, rr_gnt1}), 32'd0);
        #3;
        rst_n = 1'b1;
        set_req1(1'b1, 3'b000, 16'h0100, 16'h0200);
        #1;
        check("t5_tie_gnt0", 32'(rr_gnt0), 32'd1);
        check("t5_tie_gnt1", 32'(rr_gnt1), 32'd0);
        tick();
        check("t5_rsp_id", 32'(rr_id), 32'd0);
        #1;
        check("t5_next_tie_gnt1", 32'(rr_gnt1), 32'd1);

        // Fixed priority instance: req0 always wins ties.
        do_reset();
        set_req0(1'b1, 3'b000, 16'h0001, 16'h0002);
        set_req1(1'b1, 3'b000, 16'h0010, 16'h0020);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t6_fp_gnt0", 32'(fp_gnt0), 32'd1);
            check("t6_fp_gnt1", 32'(fp_gnt1), 32'd0);
            tick();
            check("t6_fp_rsp_id", 32'(fp_id), 32'd0);
        end
        set_req0(1'b0, 3'b000, 16'h0000, 16'h0000);
        #1;
        check("t6_fp_gnt1_idle0", 32'(fp_gnt1), 32'd1);
        tick();
        check("t6_fp_rsp_id1", 32'(fp_id), 32'd1);
        check("t6_fp_rsp_result", 32'(fp_rsp), 32'h0030);
        set_req1(1'b0, 3'b000, 16'h0000, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
